// File: rtl/axi_stream_egress_demux_if.sv
// ---------------------------------------------------------------------------
// axi_str_inf: AXI-Stream bundle shared by the ingress and egress sides of
// the egress demux.
//   tdata  [DATA_SIZE-1:0]  payload
//   tuser  [USER_SIZE-1:0]  sideband; low bits carry the destination port
//   tvalid                  beat present
//   tlast                   final beat of a packet
//   tready                  sink accepts the beat
// master drives tdata/tuser/tvalid/tlast and samples tready; slave is the
// mirror image.
// ---------------------------------------------------------------------------
interface axi_str_inf #(
  parameter int DATA_SIZE = 32,
  parameter int USER_SIZE = 16
);
  logic [DATA_SIZE-1:0] tdata;
  logic [USER_SIZE-1:0] tuser;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_stream_egress_demux.sv
// ---------------------------------------------------------------------------
// axi_stream_egress_demux
// Routes each packet of one ingress AXI-Stream, whole and in order, to one of
// NUM_OF_EGRESS_PORTS egress streams. The destination is tuser[DEST_W-1:0] of
// the first beat and stays locked until that packet's tlast beat is accepted.
// Packets whose destination is out of range are swallowed and counted.
//
// Ports:
//   clk           single clock
//   rst_n         asynchronous assert, active-low reset
//   axis_in_inf   ingress stream (slave modport)
//   axis_out_inf  egress streams [NUM_OF_EGRESS_PORTS] (master modport)
//   drop_count    dropped-packet count, saturates at 16'hFFFF
//
// Build option AXIS_EGRESS_DEMUX_FIFO_EN:
//   defined   - each egress port has a FIFO_DEPTH-beat FIFO (1-cycle latency);
//               a stalled port only holds back packets addressed to it.
//   undefined - no FIFOs; the selected egress port is driven combinationally
//               from the ingress beat and ingress tready follows its tready.
// The routing FSM, locking and drop counter are the same in both builds.
// ---------------------------------------------------------------------------
module axi_stream_egress_demux #(
  parameter int DATA_SIZE           = 32,
  parameter int USER_SIZE           = 16,
  parameter int NUM_OF_EGRESS_PORTS = 3,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_str_inf.slave         axis_in_inf,
  axi_str_inf.master        axis_out_inf [NUM_OF_EGRESS_PORTS],
  output logic [15:0]       drop_count
);

  localparam int DEST_W = $clog2(NUM_OF_EGRESS_PORTS);
  // Per-port vectors are padded to a power of two so indexing with any
  // DEST_W-bit value stays in range.
  localparam int PAD_N  = 1 << DEST_W;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                   state_reg, state_next;
  logic [DEST_W-1:0]        cur_dest_reg, cur_dest_next;
  logic [15:0]              drop_count_reg;

  logic [DEST_W-1:0]        in_dest;
  logic [DEST_W-1:0]        route_port;
  logic                     dest_ok;
  logic                     route_drop;
  logic                     port_ready;
  logic                     in_ready;
  logic                     accept;
  logic                     drop_inc;
  logic [PAD_N-1:0]         port_ready_pad;
  logic [NUM_OF_EGRESS_PORTS-1:0] push_en;

  assign in_dest = axis_in_inf.tuser[DEST_W-1:0];
  assign dest_ok = ({1'b0, in_dest} < (DEST_W+1)'(NUM_OF_EGRESS_PORTS));

  // Routing decode and next-state logic. In IDLE the route comes straight
  // from the current beat's tuser; afterwards it is the locked cur_dest.
  always_comb begin
    state_next    = state_reg;
    cur_dest_next = cur_dest_reg;
    route_port    = cur_dest_reg;
    route_drop    = 1'b0;
    drop_inc      = 1'b0;

    case (state_reg)
      IDLE: begin
        route_port = in_dest;
        route_drop = !dest_ok;
      end
      DROP:    route_drop = 1'b1;
      default: ;
    endcase

    port_ready = port_ready_pad[route_port];
    // Held low during reset so nothing is accepted while state is cleared.
    in_ready   = rst_n && (route_drop || port_ready);
    accept     = axis_in_inf.tvalid && in_ready;

    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (dest_ok) begin
            cur_dest_next = in_dest;
            if (!axis_in_inf.tlast) state_next = FWD;
          end else begin
            drop_inc = 1'b1;
            if (!axis_in_inf.tlast) state_next = DROP;
          end
        end
        FWD, DROP: begin
          if (axis_in_inf.tlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign axis_in_inf.tready = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cur_dest_reg   <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_dest_reg <= cur_dest_next;
      if (drop_inc && (drop_count_reg != 16'hFFFF))
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign drop_count = drop_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OF_EGRESS_PORTS; gi++) begin : g_push
      assign push_en[gi] = accept && !route_drop && (route_port == DEST_W'(gi));
    end
    // Unreachable pad entries: a valid route never selects them.
    for (gi = NUM_OF_EGRESS_PORTS; gi < PAD_N; gi++) begin : g_pad
      assign port_ready_pad[gi] = 1'b0;
    end
  endgenerate

`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = DATA_SIZE + USER_SIZE + 1;

  generate
    for (gi = 0; gi < NUM_OF_EGRESS_PORTS; gi++) begin : g_fifo
      logic [BEAT_W-1:0] mem [FIFO_DEPTH];
      logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
      logic [BEAT_W-1:0] head;
      logic              empty, full, pop;

      // Extra MSB on each pointer distinguishes full from empty.
      assign empty = (wr_ptr_reg == rd_ptr_reg);
      assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign pop   = !empty && axis_out_inf[gi].tready;

      // Ingress sees only 'full', so a same-cycle pop never frees a slot
      // for a push; this keeps ingress tready off the egress tready path.
      assign port_ready_pad[gi] = !full;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push_en[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop)         rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push_en[gi])
          mem[wr_ptr_reg[AW-1:0]] <= {axis_in_inf.tlast, axis_in_inf.tuser, axis_in_inf.tdata};
      end

      assign head                   = mem[rd_ptr_reg[AW-1:0]];
      assign axis_out_inf[gi].tvalid = !empty;
      assign axis_out_inf[gi].tdata  = head[DATA_SIZE-1:0];
      assign axis_out_inf[gi].tuser  = head[DATA_SIZE +: USER_SIZE];
      assign axis_out_inf[gi].tlast  = head[BEAT_W-1];
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < NUM_OF_EGRESS_PORTS; gi++) begin : g_pass
      // tvalid must not depend on tready, so it is built from the route
      // decode rather than from push_en.
      assign axis_out_inf[gi].tvalid = rst_n && axis_in_inf.tvalid && !route_drop &&
                                       (route_port == DEST_W'(gi));
      assign axis_out_inf[gi].tdata  = axis_in_inf.tdata;
      assign axis_out_inf[gi].tuser  = axis_in_inf.tuser;
      assign axis_out_inf[gi].tlast  = axis_in_inf.tlast;
      assign port_ready_pad[gi]      = axis_out_inf[gi].tready;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_axi_stream_egress_demux.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_egress_demux
// Directed bench for axi_stream_egress_demux (N=3, FIFO_DEPTH=4). Each egress
// port has a queue of expected beats, filled when the bench sees an ingress
// handshake for a beat it addressed to that port, and drained as egress
// handshakes occur. Build-dependent expectations (latency, back-pressure
// depth) follow AXIS_EGRESS_DEMUX_FIFO_EN.
// ---------------------------------------------------------------------------
module tb_axi_stream_egress_demux;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] u;
    logic        l;
  } beat_t;

`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
  localparam int STALL_ACC = 4;
`else
  localparam int STALL_ACC = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] drop_count;

  axi_str_inf #(.DATA_SIZE(32), .USER_SIZE(16)) in_if ();
  axi_str_inf #(.DATA_SIZE(32), .USER_SIZE(16)) out_if [3] ();

  logic        o_valid [3];
  logic        o_last  [3];
  logic        o_ready [3];
  logic [31:0] o_data  [3];
  logic [15:0] o_user  [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      assign o_valid[gi]      = out_if[gi].tvalid;
      assign o_last[gi]       = out_if[gi].tlast;
      assign o_data[gi]       = out_if[gi].tdata;
      assign o_user[gi]       = out_if[gi].tuser;
      assign out_if[gi].tready = o_ready[gi];
    end
  endgenerate

  axi_stream_egress_demux #(
    .DATA_SIZE(32), .USER_SIZE(16), .NUM_OF_EGRESS_PORTS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .axis_in_inf  (in_if),
    .axis_out_inf (out_if),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests  = 0;
  int    failed = 0;
  int    cur_port = 3;
  bit    last_acc = 1'b0;
  beat_t exp_q [3][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record ingress/egress handshakes just before the edge.
  task automatic tick();
    beat_t b;
    beat_t got;
    #1;
    last_acc = in_if.tvalid && in_if.tready;
    if (last_acc && cur_port < 3) begin
      b = {in_if.tdata, in_if.tuser, in_if.tlast};
      exp_q[cur_port].push_back(b);
    end
    for (int p = 0; p < 3; p++) begin
      if (o_valid[p] && o_ready[p]) begin
        got = {o_data[p], o_user[p], o_last[p]};
        if (exp_q[p].size() == 0) begin
          chk($sformatf("unexpected_beat_p%0d", p), {63'd0, o_valid[p]}, 64'd0);
        end else begin
          b = exp_q[p].pop_front();
          chk($sformatf("beat_p%0d", p), 64'(got), 64'(b));
          $display("[TB] port %0d beat data=%h user=%h last=%0b", p, got.d, got.u, got.l);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [15:0] u, input logic l, input int port);
    int n;
    n = 0;
    in_if.tdata  = d;
    in_if.tuser  = u;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    cur_port     = port;
    last_acc     = 1'b0;
    while (!last_acc && n < 50) begin
      tick();
      n++;
    end
    chk("send_accepted", {63'd0, last_acc}, 64'd1);
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
  endtask

  initial begin
    int idx;
    rst_n        = 1'b1;
    in_if.tdata  = '0;
    in_if.tuser  = 16'd1;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    for (int p = 0; p < 3; p++) o_ready[p] = 1'b1;

    // Reset: a valid beat is presented, yet nothing may move.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_tready", {63'd0, in_if.tready}, 64'd0);
    chk("rst_valid_p0", {63'd0, o_valid[0]}, 64'd0);
    chk("rst_valid_p1", {63'd0, o_valid[1]}, 64'd0);
    chk("rst_valid_p2", {63'd0, o_valid[2]}, 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    in_if.tvalid = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat packet to port 1.
    in_if.tdata  = 32'hA5A5_0001;
    in_if.tuser  = 16'd1;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    cur_port     = 1;
    #1;
    chk("single_in_tready", {63'd0, in_if.tready}, 64'd1);
    chk("single_idle_p0", {63'd0, o_valid[0]}, 64'd0);
    chk("single_idle_p2", {63'd0, o_valid[2]}, 64'd0);
`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    chk("single_not_yet_p1", {63'd0, o_valid[1]}, 64'd0);
`else
    chk("single_valid_p1", {63'd0, o_valid[1]}, 64'd1);
    chk("single_data_p1", 64'(o_data[1]), 64'h0000_0000_A5A5_0001);
`endif
    tick();
    in_if.tvalid = 1'b0;
`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    #1;
    chk("single_latency_p1", {63'd0, o_valid[1]}, 64'd1);
    chk("single_data_p1", 64'(o_data[1]), 64'h0000_0000_A5A5_0001);
    chk("single_last_p1", {63'd0, o_last[1]}, 64'd1);
`endif
    drain();
    chk("single_drop_count", 64'(drop_count), 64'd0);

    // 4-beat packet: first beat tuser=2, later beats tuser=0 must not reroute.
    for (int k = 0; k < 4; k++) begin
      send(32'h2000_0000 + 32'(k), (k == 0) ? 16'd2 : 16'd0, (k == 3), 2);
      if (k == 1) begin
        #1;
        chk("lock_no_p0", {63'd0, o_valid[0]}, 64'd0);
      end
    end
    drain();

    // Port 0 stalled, 6-beat packet: back-pressure then full drain in order.
    o_ready[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_if.tdata  = 32'h3000_0000 + 32'(idx);
      in_if.tuser  = (idx == 0) ? 16'd0 : 16'd2;
      in_if.tlast  = (idx == 5);
      in_if.tvalid = 1'b1;
      cur_port     = 0;
      tick();
      if (last_acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'(STALL_ACC));
    #1;
    chk("stall_in_tready", {63'd0, in_if.tready}, 64'd0);
`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    chk("stall_head_valid", {63'd0, o_valid[0]}, 64'd1);
    chk("stall_head_data", 64'(o_data[0]), 64'h0000_0000_3000_0000);
`endif
    o_ready[0] = 1'b1;
    while (idx < 6) begin
      send(32'h3000_0000 + 32'(idx), (idx == 0) ? 16'd0 : 16'd2, (idx == 5), 0);
      idx++;
    end
    drain();

    // Invalid destination (3), 3 beats: always accepted, nothing emitted.
    for (int k = 0; k < 3; k++) begin
      in_if.tdata  = 32'h4000_0000 + 32'(k);
      in_if.tuser  = (k == 0) ? 16'd3 : 16'(k);
      in_if.tlast  = (k == 2);
      in_if.tvalid = 1'b1;
      cur_port     = 3;
      #1;
      chk("drop_in_tready", {63'd0, in_if.tready}, 64'd1);
      tick();
    end
    in_if.tvalid = 1'b0;
    drain();
    chk("drop_count_one", 64'(drop_count), 64'd1);

    // Saturation: 65540 single-beat invalid packets in a row.
    in_if.tdata  = 32'h4444_0000;
    in_if.tuser  = 16'h0003;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    cur_port     = 3;
    repeat (65533) tick();
    in_if.tvalid = 1'b0;
    #1;
    chk("drop_count_fffe", 64'(drop_count), 64'h0000_0000_0000_FFFE);
    in_if.tvalid = 1'b1;
    repeat (7) tick();
    in_if.tvalid = 1'b0;
    #1;
    chk("drop_count_sat", 64'(drop_count), 64'h0000_0000_0000_FFFF);

`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    // Ports 0,1,0 with port 0 stalled: port 1 completes, port 0 order kept.
    o_ready[0] = 1'b0;
    send(32'h5000_0000, 16'd0, 1'b0, 0);
    send(32'h5000_0001, 16'd1, 1'b1, 0);
    send(32'h5100_0000, 16'd1, 1'b0, 1);
    send(32'h5100_0001, 16'd0, 1'b1, 1);
    send(32'h5200_0000, 16'd0, 1'b0, 0);
    send(32'h5200_0001, 16'd2, 1'b0, 0);
    in_if.tdata  = 32'h5200_0002;
    in_if.tuser  = 16'd1;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    cur_port     = 0;
    tick();
    tick();
    chk("order_port1_done", 64'(exp_q[1].size()), 64'd0);
    chk("order_wait_tready", {63'd0, in_if.tready}, 64'd0);
    o_ready[0] = 1'b1;
    send(32'h5200_0002, 16'd1, 1'b1, 0);
    drain();
`endif

    // Reset mid-packet, then a new packet routes by its own first beat.
`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    o_ready[1] = 1'b0;
`endif
    send(32'h6000_0000, 16'd1, 1'b0, 1);
`ifdef AXIS_EGRESS_DEMUX_FIFO_EN
    #1;
    chk("midpkt_fifo_busy", {63'd0, o_valid[1]}, 64'd1);
`endif
    in_if.tdata  = 32'h6000_0001;
    in_if.tuser  = 16'd1;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b1;
    rst_n        = 1'b0;
    #1;
    chk("midrst_in_tready", {63'd0, in_if.tready}, 64'd0);
    chk("midrst_valid_p0", {63'd0, o_valid[0]}, 64'd0);
    chk("midrst_valid_p1", {63'd0, o_valid[1]}, 64'd0);
    chk("midrst_valid_p2", {63'd0, o_valid[2]}, 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    for (int p = 0; p < 3; p++) exp_q[p].delete();
    in_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    o_ready[1] = 1'b1;
    send(32'h7000_0000, 16'd2, 1'b1, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
